// File: rtl/mac_dot_seq.sv
// Dot-product sequencer feeding an FP16 MAC. Operand pairs arrive one at a time. Each MAC
// result is fed back as the next C operand. After len pairs the accumulated value is
// presented on the output port. The block does no FP arithmetic itself.
module mac_dot_seq #(
  parameter int unsigned MAC_LATENCY = 4,
  parameter int unsigned LEN_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  output logic [15:0]      mac_c,
  input  logic [15:0]      mac_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             busy
);

  localparam int unsigned WAIT_W = $clog2(MAC_LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StFetch, StWait, StOut} state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   elem_cnt_q, elem_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0]        acc_q, acc_d;
  logic [15:0]        mac_a_q, mac_a_d;
  logic [15:0]        mac_b_q, mac_b_d;
  logic [15:0]        mac_c_q, mac_c_d;
  logic [15:0]        out_data_q, out_data_d;
  logic [LEN_W-1:0]   elem_next;

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      elem_cnt_q <= '0;
      wait_cnt_q <= '0;
      acc_q      <= '0;
      mac_a_q    <= '0;
      mac_b_q    <= '0;
      mac_c_q    <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      elem_cnt_q <= elem_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      acc_q      <= acc_d;
      mac_a_q    <= mac_a_d;
      mac_b_q    <= mac_b_d;
      mac_c_q    <= mac_c_d;
      out_data_q <= out_data_d;
    end
  end

  assign elem_next = elem_cnt_q + LEN_W'(1);

  // Next-state and datapath update; everything holds unless the current state changes it.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    elem_cnt_d = elem_cnt_q;
    wait_cnt_d = wait_cnt_q;
    acc_d      = acc_q;
    mac_a_d    = mac_a_q;
    mac_b_d    = mac_b_q;
    mac_c_d    = mac_c_q;
    out_data_d = out_data_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d      = len;
          acc_d      = bias;
          elem_cnt_d = '0;
          if (len == '0) begin
            // Empty job: the bias itself is the result.
            out_data_d = bias;
            state_d    = StOut;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        if (in_valid) begin
          mac_a_d    = in_a;
          mac_b_d    = in_b;
          mac_c_d    = acc_q;
          wait_cnt_d = '0;
          state_d    = StWait;
        end
      end
      StWait: begin
        // mac_* became valid on entry (wait_cnt 0); the result lands MAC_LATENCY cycles later.
        if (wait_cnt_q == WAIT_W'(MAC_LATENCY)) begin
          acc_d      = mac_acc;
          elem_cnt_d = elem_next;
          if (elem_next == len_q) begin
            out_data_d = mac_acc;
            state_d    = StOut;
          end else begin
            state_d = StFetch;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      StOut: begin
        if (out_ready) begin
          mac_a_d = '0;
          mac_b_d = '0;
          mac_c_d = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready  = (state_q == StFetch);
  assign out_valid = (state_q == StOut);
  assign busy      = (state_q != StIdle);
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_c     = mac_c_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq. A small table-driven MAC model stands in for the FP16 MAC:
// it knows the hand-computed a*b+c results used by the scenarios below.
module tb_mac_dot_seq;

  localparam int unsigned MAC_LAT = 4;
  localparam int unsigned LEN_W   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [15:0]      bias;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a, in_b;
  logic [15:0]      mac_a, mac_b, mac_c;
  logic [15:0]      mac_acc;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic             busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] pa [4];
  logic [15:0] pb [4];
  logic [15:0] pipe [MAC_LAT];

  mac_dot_seq #(
    .MAC_LATENCY(MAC_LAT),
    .LEN_W      (LEN_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .bias     (bias),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .mac_a    (mac_a),
    .mac_b    (mac_b),
    .mac_c    (mac_c),
    .mac_acc  (mac_acc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Hand-computed FP16 a*b+c for the triples the scenarios produce.
  function automatic logic [15:0] fp16_mac(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] c);
    logic [47:0] key;
    key = {a, b, c};
    case (key)
      48'h3c00_3c00_3800: return 16'h3e00;  // 1*1+0.5
      48'h3c00_3c00_0000: return 16'h3c00;  // 1*1+0
      48'h4000_4000_3c00: return 16'h4500;  // 2*2+1
      48'h3c00_c000_4500: return 16'h4200;  // 1*-2+5
      48'h3c00_4000_0000: return 16'h4000;  // 1*2+0
      48'h3c00_c000_4000: return 16'h0000;  // 1*-2+2
      48'h4400_4400_0000: return 16'h4c00;  // 4*4+0
      default:            return 16'hbad0;
    endcase
  endfunction

  // MAC pipeline model: result appears MAC_LAT cycles after the operands.
  always_ff @(posedge clk) begin
    pipe[0] <= fp16_mac(mac_a, mac_b, mac_c);
    for (int i = 1; i < int'(MAC_LAT); i++) pipe[i] <= pipe[i-1];
  end
  assign mac_acc = pipe[MAC_LAT-1];

  // Runs one job from start to output handshake and reports what it saw.
  task automatic drive_job(input int n, input logic [15:0] b, input int gap, input int hold,
                           input bit mid_start, output logic [15:0] res, output int out_cyc,
                           output int rdy_cnt, output int busy_bad, output int stable_bad,
                           output logic [15:0] mac_or, output bit post_ok, output bit timeout);
    int idx, gw, hc, cyc;
    bit seen;
    idx = 0; gw = 0; hc = hold; seen = 0; cyc = 0;
    res = '0; out_cyc = -1; rdy_cnt = 0; busy_bad = 0; stable_bad = 0;
    mac_or = '1; post_ok = 0; timeout = 1;
    @(negedge clk);
    start = 1'b1; len = n[LEN_W-1:0]; bias = b;
    // A pair offered alongside start must not be taken.
    in_valid = 1'b1; in_a = 16'h7777; in_b = 16'h7777; out_ready = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (mid_start && cyc == 3) begin
        start = 1'b1; len = 8'd1; bias = 16'h4c00;
      end
      if (!busy) busy_bad++;
      if (in_ready) begin
        rdy_cnt++;
        if (gw > 0) begin
          in_valid = 1'b0; gw--;
        end else if (idx < n) begin
          in_valid = 1'b1; in_a = pa[idx]; in_b = pb[idx]; idx++; gw = gap;
        end else begin
          in_valid = 1'b0;
        end
      end else begin
        in_valid = 1'b0; in_a = 16'h7777; in_b = 16'h7777;
      end
      if (out_valid) begin
        if (!seen) begin
          seen = 1; out_cyc = cyc; res = out_data;
        end
        if (hc > 0) begin
          out_ready = 1'b0; hc--;
          if (out_data !== res) stable_bad++;
        end else begin
          out_ready = 1'b1;
          @(negedge clk);
          out_ready = 1'b0; start = 1'b0;
          post_ok = !out_valid && !busy;
          mac_or  = mac_a | mac_b | mac_c;
          timeout = 0;
          break;
        end
      end else if (seen) begin
        stable_bad++;
      end
    end
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; len = '0; bias = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++;
    if ({in_ready, out_valid, busy} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b want 000", {in_ready, out_valid, busy});
    end
    total++;
    if ((mac_a | mac_b | mac_c | out_data) !== 16'h0000) begin
      bad++; $display("FAIL reset_data: got %h/%h/%h/%h want 0", mac_a, mac_b, mac_c, out_data);
    end
  endtask

  task automatic test_single();
    logic [15:0] res, mor; int oc, rc, bb, sb; bit pok, to;
    pa[0] = 16'h3c00; pb[0] = 16'h3c00;
    drive_job(1, 16'h3800, 0, 0, 0, res, oc, rc, bb, sb, mor, pok, to);
    total++;
    if (to) begin bad++; $display("FAIL single_timeout: got timeout want completion"); end
    total++;
    if (res !== 16'h3e00) begin bad++; $display("FAIL single_result: got %h want 3e00", res); end
    total++;
    if (oc !== int'(MAC_LAT) + 3) begin
      bad++; $display("FAIL single_cycle: got %0d want %0d", oc, MAC_LAT + 3);
    end
    total++;
    if (bb !== 0) begin bad++; $display("FAIL single_busy: got %0d low cycles want 0", bb); end
    total++;
    if (!pok || mor !== 16'h0000) begin
      bad++; $display("FAIL single_post: got ok=%0d mac=%h want ok=1 mac=0000", pok, mor);
    end
  endtask

  task automatic test_three();
    logic [15:0] res, mor; int oc, rc, bb, sb; bit pok, to;
    pa[0] = 16'h3c00; pb[0] = 16'h3c00;
    pa[1] = 16'h4000; pb[1] = 16'h4000;
    pa[2] = 16'h3c00; pb[2] = 16'hc000;
    drive_job(3, 16'h0000, 0, 0, 0, res, oc, rc, bb, sb, mor, pok, to);
    total++;
    if (res !== 16'h4200) begin bad++; $display("FAIL three_result: got %h want 4200", res); end
    total++;
    if (rc !== 3) begin bad++; $display("FAIL three_ready_cnt: got %0d want 3", rc); end
    total++;
    if (oc !== 1 + 3 * (int'(MAC_LAT) + 2)) begin
      bad++; $display("FAIL three_cycle: got %0d want %0d", oc, 1 + 3 * (MAC_LAT + 2));
    end
  endtask

  task automatic test_len_zero();
    logic [15:0] res, mor; int oc, rc, bb, sb; bit pok, to;
    drive_job(0, 16'hc000, 0, 0, 0, res, oc, rc, bb, sb, mor, pok, to);
    total++;
    if (res !== 16'hc000) begin bad++; $display("FAIL zero_result: got %h want c000", res); end
    total++;
    if (oc !== 1) begin bad++; $display("FAIL zero_cycle: got %0d want 1", oc); end
    total++;
    if (rc !== 0) begin bad++; $display("FAIL zero_ready: got %0d want 0", rc); end
    total++;
    if (!pok) begin bad++; $display("FAIL zero_post: got ok=0 want ok=1"); end
  endtask

  task automatic test_stalls();
    logic [15:0] res, mor; int oc, rc, bb, sb; bit pok, to;
    pa[0] = 16'h3c00; pb[0] = 16'h4000;
    pa[1] = 16'h3c00; pb[1] = 16'hc000;
    drive_job(2, 16'h0000, 3, 5, 1, res, oc, rc, bb, sb, mor, pok, to);
    total++;
    if (res !== 16'h0000) begin bad++; $display("FAIL stall_result: got %h want 0000", res); end
    total++;
    if (oc !== 1 + 2 * (int'(MAC_LAT) + 2) + 3) begin
      bad++; $display("FAIL stall_cycle: got %0d want %0d", oc, 1 + 2 * (MAC_LAT + 2) + 3);
    end
    total++;
    if (sb !== 0) begin bad++; $display("FAIL stall_hold: got %0d unstable cycles want 0", sb); end
    total++;
    if (bb !== 0 || !pok) begin
      bad++; $display("FAIL stall_busy: got low=%0d ok=%0d want low=0 ok=1", bb, pok);
    end
  endtask

  task automatic test_rst_mid();
    logic [15:0] res, mor; int oc, rc, bb, sb, ov; bit pok, to;
    @(negedge clk);
    start = 1'b1; len = 8'd3; bias = 16'h0000; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);  // cycle 1: FETCH
    start = 1'b0; in_valid = 1'b1; in_a = 16'h3c00; in_b = 16'h3c00;
    @(negedge clk);  // cycle 2: WAIT
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy, in_ready, out_valid} !== 3'b000) begin
      bad++; $display("FAIL rstmid_flags: got %b want 000", {busy, in_ready, out_valid});
    end
    total++;
    if ((mac_a | mac_b | mac_c) !== 16'h0000) begin
      bad++; $display("FAIL rstmid_mac: got %h/%h/%h want 0", mac_a, mac_b, mac_c);
    end
    ov = 0;
    in_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++;
    if (ov !== 0) begin bad++; $display("FAIL rstmid_no_out: got %0d valid cycles want 0", ov); end
    pa[0] = 16'h4400; pb[0] = 16'h4400;
    drive_job(1, 16'h0000, 0, 0, 0, res, oc, rc, bb, sb, mor, pok, to);
    total++;
    if (res !== 16'h4c00) begin bad++; $display("FAIL rstmid_next: got %h want 4c00", res); end
    total++;
    if (oc !== int'(MAC_LAT) + 3) begin
      bad++; $display("FAIL rstmid_next_cycle: got %0d want %0d", oc, MAC_LAT + 3);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_len_zero();
    test_stalls();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
